// File: rtl/alu_if.sv
// alu_if: operand, control, result and flag bundle between the datapath and the ALU.
// The master side drives operands and the operation code; the slave side (the ALU)
// returns the registered result together with its four status flags.
interface alu_if;

    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  aluControl;
    logic [31:0] ALUResult;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        negative;

    modport master (
        output SrcA,
        output SrcB,
        output aluControl,
        input  ALUResult,
        input  zero,
        input  carry,
        input  overflow,
        input  negative
    );

    modport slave (
        input  SrcA,
        input  SrcB,
        input  aluControl,
        output ALUResult,
        output zero,
        output carry,
        output overflow,
        output negative
    );

endinterface

// File: rtl/alu.sv
// alu: 32-bit integer ALU for the single-cycle RISC-V datapath.
// Eight operations chosen by aluControl; result and flags are registered on the
// rising edge of clk, one cycle of latency, no enable.
// Build option: define ALU_SRA_EN to turn code 111 into an arithmetic right shift
// (sign fill); left undefined, code 111 is a logical right shift (zero fill).
module alu (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_e;

    alu_op_e     op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;

    logic        do_sub;
    logic [31:0] b_eff;
    logic [32:0] sum_full;
    logic [31:0] sum;
    logic        sum_cout;
    logic        sum_ovf;
    logic        slt_bit;

    logic [31:0] shl_res;
    logic [31:0] shr_res;
    logic        shr_fill;

    logic [31:0] result_d;
    logic        carry_d;
    logic        overflow_d;

    logic [31:0] result_q;
    logic        zero_q;
    logic        carry_q;
    logic        overflow_q;
    logic        negative_q;

    assign op    = alu_op_e'(bus.aluControl);
    assign src_a = bus.SrcA;
    assign src_b = bus.SrcB;

    // Only the low five bits of B are a meaningful shift distance for a 32-bit word.
    assign shamt = src_b[4:0];

    // Subtraction (and slt, which reuses the subtractor) is A + ~B + 1.
    assign do_sub   = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff    = do_sub ? ~src_b : src_b;
    assign sum_full = {1'b0, src_a} + {1'b0, b_eff} + {32'd0, do_sub};
    assign sum      = sum_full[31:0];
    assign sum_cout = sum_full[32];

    // Signed overflow: both adder inputs share a sign and the sum's sign differs.
    // With b_eff already inverted for subtraction this covers add and sub alike.
    assign sum_ovf  = (src_a[31] == b_eff[31]) && (sum[31] != src_a[31]);

    // Signed less-than from the subtractor: sign of the difference corrected by overflow.
    assign slt_bit  = sum[31] ^ sum_ovf;

`ifdef ALU_SRA_EN
    assign shr_fill = src_a[31];
`else
    assign shr_fill = 1'b0;
`endif

    // Left shift, zero fill from the bottom.
    always_comb begin
        shl_res = src_a << shamt;
    end

    // Right shift as a five-stage barrel so the fill bit can be sign or zero.
    always_comb begin
        logic [31:0] stage;
        stage = src_a;
        if (shamt[0]) stage = {{1{shr_fill}},  stage[31:1]};
        if (shamt[1]) stage = {{2{shr_fill}},  stage[31:2]};
        if (shamt[2]) stage = {{4{shr_fill}},  stage[31:4]};
        if (shamt[3]) stage = {{8{shr_fill}},  stage[31:8]};
        if (shamt[4]) stage = {{16{shr_fill}}, stage[31:16]};
        shr_res = stage;
    end

    // Select the operation result; carry and overflow only mean something for add/sub.
    always_comb begin
        result_d   = 32'd0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                result_d   = sum;
                carry_d    = sum_cout;
                overflow_d = sum_ovf;
            end
            OP_SUB: begin
                result_d   = sum;
                carry_d    = sum_cout;
                overflow_d = sum_ovf;
            end
            OP_AND: result_d = src_a & src_b;
            OP_OR:  result_d = src_a | src_b;
            OP_XOR: result_d = src_a ^ src_b;
            OP_SLT: result_d = {31'd0, slt_bit};
            OP_SLL: result_d = shl_res;
            OP_SRL: result_d = shr_res;
            default: result_d = 32'd0;
        endcase
    end

    // Capture result and flags every edge; reset drops to a zero result with zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= 32'd0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= (result_d == 32'd0);
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= result_d[31];
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.negative  = negative_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu with hand-computed expected values.
// Honours ALU_SRA_EN for the expected value of the right shift.
module tb_alu;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_if aluBus ();

    alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (aluBus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expResult, input logic expZero,
                               input logic expCarry, input logic expOvf, input logic expNeg);
        checkField({tag, ".result"},   aluBus.ALUResult,      expResult);
        checkField({tag, ".zero"},     {31'd0, aluBus.zero},     {31'd0, expZero});
        checkField({tag, ".carry"},    {31'd0, aluBus.carry},    {31'd0, expCarry});
        checkField({tag, ".overflow"}, {31'd0, aluBus.overflow}, {31'd0, expOvf});
        checkField({tag, ".negative"}, {31'd0, aluBus.negative}, {31'd0, expNeg});
    endtask

    // Drive operands on the falling edge, let one rising edge capture, sample 1 later.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        aluBus.SrcA       = a;
        aluBus.SrcB       = b;
        aluBus.aluControl = op;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expSrl;
    logic        expSrlNeg;

    initial begin
        checks = 0;
        errors = 0;
`ifdef ALU_SRA_EN
        expSrl    = 32'hF800_0000;
        expSrlNeg = 1'b1;
`else
        expSrl    = 32'h0800_0000;
        expSrlNeg = 1'b0;
`endif
        rst_n             = 1'b1;
        aluBus.SrcA       = $urandom;
        aluBus.SrcB       = $urandom;
        aluBus.aluControl = 3'($urandom_range(0, 7));

        // Asynchronous reset before any rising edge.
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_async", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("reset_held", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add.
        applyStimulus(32'h0000_0004, 32'h0000_0002, 3'b000);
        checkOutput("add_small", 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 3'b000);
        checkOutput("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
        checkOutput("add_carry", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Sub.
        applyStimulus(32'h1234_5678, 32'h1234_5678, 3'b001);
        checkOutput("sub_equal", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_0000, 32'h0000_0001, 3'b001);
        checkOutput("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b001);
        checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);

        // Set-less-than, including the overflowing compare.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 3'b101);
        checkOutput("slt_neg_lt", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 3'b101);
        checkOutput("slt_swap", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 3'b101);
        checkOutput("slt_ovf", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Logic.
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010);
        checkOutput("and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011);
        checkOutput("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100);
        checkOutput("xor", 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Shifts: B = 0x24 shifts by 4, upper bits ignored; B = 0x20 shifts by 0.
        applyStimulus(32'h8000_0001, 32'h0000_0024, 3'b110);
        checkOutput("sll4", 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h8000_0001, 32'h0000_0024, 3'b111);
        checkOutput("srl4", expSrl, 1'b0, 1'b0, 1'b0, expSrlNeg);
        applyStimulus(32'h1234_5678, 32'h0000_0020, 3'b110);
        checkOutput("sll0", 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h4000_0000, 32'hFFFF_FFFE, 3'b111);
        checkOutput("srl30", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Outputs are registered: changing inputs between edges must not move them.
        @(negedge clk);
        aluBus.SrcA       = 32'h0000_0003;
        aluBus.SrcB       = 32'h0000_0005;
        aluBus.aluControl = 3'b000;
        #1 checkOutput("hold", 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("hold_capture", 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back operations, one per cycle.
        applyStimulus(32'h0000_000A, 32'h0000_0003, 3'b001);
        checkOutput("b2b_sub", 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0000_000A, 32'h0000_0003, 3'b000);
        checkOutput("b2b_add", 32'h0000_000D, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_000A, 32'h0000_0003, 3'b100);
        checkOutput("b2b_xor", 32'h0000_0009, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation discards the pending result; release captures on next edge.
        @(negedge clk);
        aluBus.SrcA       = 32'h0000_0020;
        aluBus.SrcB       = 32'h0000_0001;
        aluBus.aluControl = 3'b110;
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_mid", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("reset_mid_edge", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("reset_release", 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
